// File: rtl/crc_ci_pkg.sv
// Shared definitions for the CRC custom-instruction initiator.
// Contains the ci_n opcode constants and the controller state encoding.
package crc_ci_pkg;

   localparam logic [2:0] CI_N_LOAD = 3'd0;
   localparam logic [2:0] CI_N_B1   = 3'd1;
   localparam logic [2:0] CI_N_B2   = 3'd2;
   localparam logic [2:0] CI_N_B3   = 3'd3;
   localparam logic [2:0] CI_N_B4   = 3'd4;
   localparam logic [2:0] CI_N_B8   = 3'd5;
   localparam logic [2:0] CI_N_READ = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ACC   = 3'd2,
      ST_ISSUE = 3'd3,
      ST_WAIT  = 3'd4,
      ST_READ  = 3'd5,
      ST_OUT   = 3'd6
   } state_t;

endpackage

// File: rtl/crc_ci_byte_packer.sv
// Packs accepted bytes little-endian into a 32-bit word for the CRC custom instruction.
// Tracks the byte count of the current word and whether the packet's last byte was seen.
module crc_ci_byte_packer
   import crc_ci_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        clear_last,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   input  logic        last_in,
   output logic [31:0] word,
   output logic [2:0]  count,
   output logic        last
);

   // clear drops the word after it is issued; clear_last also starts a fresh packet
   always_ff @(posedge clk) begin
      if (reset || clear_last) begin
         word  <= 32'h0;
         count <= 3'd0;
         last  <= 1'b0;
      end else if (clear) begin
         word  <= 32'h0;
         count <= 3'd0;
         last  <= last;
      end else if (byte_en) begin
         case (count)
            3'd0:    word[7:0]   <= byte_in;
            3'd1:    word[15:8]  <= byte_in;
            3'd2:    word[23:16] <= byte_in;
            3'd3:    word[31:24] <= byte_in;
            default: word        <= word;
         endcase
         count <= count + 3'd1;
         last  <= last_in;
      end else begin
         word  <= word;
         count <= count;
         last  <= last;
      end
   end

endmodule

// File: rtl/crc_ci_initiator.sv
// Streams packet bytes through a CRC custom instruction (seed, 1..4-byte updates, read-back).
// Optional op timeout with err strobe and packet drain: define CRC_CI_INIT_TIMEOUT_EN.
module crc_ci_initiator
   import crc_ci_pkg::*;
#(
   parameter logic [31:0] SEED           = 32'hFFFF_FFFF,
   parameter int unsigned TIMEOUT_CYCLES = 32'd16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic [31:0] crc_out,
   output logic        crc_valid,
   output logic        err,
   output logic        ci_clk_en,
   output logic        ci_start,
   output logic [31:0] ci_dataa,
   output logic [31:0] ci_datab,
   output logic [2:0]  ci_n,
   input  logic        ci_done,
   input  logic [31:0] ci_result
);

   state_t      state_r;
   state_t      state_s;
   logic        drain_r;
   logic        drain_s;
   logic        ready_s;
   logic [31:0] crc_s;
   logic        crc_valid_s;
   logic        err_s;
   logic        clk_en_s;
   logic        start_s;
   logic [2:0]  n_s;
   logic [31:0] dataa_s;
   logic        accept_s;
   logic        op_done_s;
   logic        timeout_s;
   logic        pack_en_s;
   logic        pack_clear_s;
   logic        pack_clear_last_s;
   logic [31:0] pack_word_s;
   logic [2:0]  pack_count_s;
   logic        pack_last_s;

   assign accept_s  = s_valid & s_ready;
   assign op_done_s = ci_clk_en & ci_done;
   assign ci_datab  = 32'h0;

   crc_ci_byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (pack_clear_s),
      .clear_last (pack_clear_last_s),
      .byte_en    (pack_en_s),
      .byte_in    (s_data),
      .last_in    (s_last),
      .word       (pack_word_s),
      .count      (pack_count_s),
      .last       (pack_last_s)
   );

`ifdef CRC_CI_INIT_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);
   logic [CNT_W-1:0] wait_cnt_r;

   assign timeout_s = ci_clk_en & ~ci_done & (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 32'd1));

   // Counts the enabled cycles of the op in flight; restarts for every new op
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_r <= '0;
      end else if (ci_clk_en && !ci_done && !timeout_s) begin
         wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
         wait_cnt_r <= '0;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state and next-output logic; every ci_* output is re-registered each cycle
   always_comb begin
      state_s           = state_r;
      drain_s           = drain_r;
      crc_s             = crc_out;
      crc_valid_s       = 1'b0;
      err_s             = 1'b0;
      start_s           = 1'b0;
      clk_en_s          = 1'b0;
      n_s               = CI_N_LOAD;
      dataa_s           = 32'h0;
      pack_en_s         = 1'b0;
      pack_clear_s      = 1'b0;
      pack_clear_last_s = 1'b0;

      // an op that has not completed keeps its operands on the bus
      if (ci_clk_en && !ci_done) begin
         clk_en_s = 1'b1;
         n_s      = ci_n;
         dataa_s  = ci_dataa;
      end else begin
         clk_en_s = 1'b0;
      end

      case (state_r)
         ST_IDLE: begin
            if (drain_r) begin
               if (accept_s && s_last) begin
                  drain_s = 1'b0;
               end else begin
                  drain_s = 1'b1;
               end
            end else if (s_valid) begin
               state_s           = ST_LOAD;
               start_s           = 1'b1;
               clk_en_s          = 1'b1;
               n_s               = CI_N_LOAD;
               dataa_s           = SEED;
               pack_clear_last_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (op_done_s) begin
               state_s = ST_ACC;
            end else begin
               state_s = ST_LOAD;
            end
         end
         ST_ACC: begin
            if (accept_s) begin
               pack_en_s = 1'b1;
               if ((pack_count_s == 3'd3) || s_last) begin
                  state_s = ST_ISSUE;
               end else begin
                  state_s = ST_ACC;
               end
            end else begin
               state_s = ST_ACC;
            end
         end
         ST_ISSUE: begin
            state_s      = ST_WAIT;
            start_s      = 1'b1;
            clk_en_s     = 1'b1;
            n_s          = pack_count_s;
            dataa_s      = pack_word_s;
            pack_clear_s = 1'b1;
         end
         ST_WAIT: begin
            if (op_done_s) begin
               if (pack_last_s) begin
                  state_s  = ST_READ;
                  start_s  = 1'b1;
                  clk_en_s = 1'b1;
                  n_s      = CI_N_READ;
                  dataa_s  = 32'h0;
               end else begin
                  state_s = ST_ACC;
               end
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_READ: begin
            if (op_done_s) begin
               crc_s       = ci_result;
               crc_valid_s = 1'b1;
               state_s     = ST_OUT;
            end else begin
               state_s = ST_READ;
            end
         end
         ST_OUT: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // abandoning an op mid-packet leaves the rest of that packet to be drained
      if (timeout_s) begin
         state_s  = ST_IDLE;
         start_s  = 1'b0;
         clk_en_s = 1'b0;
         n_s      = CI_N_LOAD;
         dataa_s  = 32'h0;
         err_s    = 1'b1;
         drain_s  = ~pack_last_s;
      end else begin
         err_s = 1'b0;
      end

      ready_s = (state_s == ST_ACC) || ((state_s == ST_IDLE) && drain_s);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         drain_r   <= 1'b0;
         s_ready   <= 1'b0;
         crc_out   <= 32'h0;
         crc_valid <= 1'b0;
         err       <= 1'b0;
         ci_clk_en <= 1'b0;
         ci_start  <= 1'b0;
         ci_n      <= 3'd0;
         ci_dataa  <= 32'h0;
      end else begin
         state_r   <= state_s;
         drain_r   <= drain_s;
         s_ready   <= ready_s;
         crc_out   <= crc_s;
         crc_valid <= crc_valid_s;
         err       <= err_s;
         ci_clk_en <= clk_en_s;
         ci_start  <= start_s;
         ci_n      <= n_s;
         ci_dataa  <= dataa_s;
      end
   end

endmodule
